// File: rtl/cafeteira_controle_pedidos.sv
// Coffee order controller.
// Assembles 4-byte frames (A5, drink, size, checksum) from the serial
// receiver and validates them. Accepted orders go into a small show-ahead
// FIFO, which is drained by the brewing unit through a valid/ready handshake.
module cafeteira_controle_pedidos #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CICLOS = 50000,
    parameter int N_BEBIDAS      = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        pronto,
    input  logic [7:0]                  dados,
    input  logic                        pedido_aceito,
    output logic                        pedido_valido,
    output logic [1:0]                  pedido_bebida,
    output logic [1:0]                  pedido_tamanho,
    output logic                        fila_vazia,
    output logic                        fila_cheia,
    output logic [$clog2(FIFO_DEPTH):0] ocupacao,
    output logic                        erro,
    output logic [1:0]                  erro_codigo
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

    localparam logic [7:0]    CABECALHO    = 8'hA5;
    localparam logic [7:0]    N_BEB_B      = 8'(N_BEBIDAS);
    localparam logic [TW-1:0] TIMER_ULTIMO = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [CW-1:0] CHEIA_VAL    = CW'(FIFO_DEPTH);

    localparam logic [1:0] COD_INVALIDO = 2'd1;
    localparam logic [1:0] COD_TIMEOUT  = 2'd2;
    localparam logic [1:0] COD_CHEIA    = 2'd3;

    typedef enum logic [1:0] {
        ESPERA_CAB,
        ESPERA_BEB,
        ESPERA_TAM,
        ESPERA_CHK
    } estado_t;

    // Parser state and registered outputs
    estado_t       estado_reg;
    logic [TW-1:0] timer_reg;
    logic [7:0]    bebida_reg;
    logic [7:0]    tamanho_reg;
    logic          push_req_reg;
    logic [3:0]    push_dado_reg;
    logic          erro_reg;
    logic [1:0]    erro_codigo_reg;

    // Order queue
    logic [3:0]    mem_reg [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic frame_ok;
    logic pop;
    logic push_ok;
    logic push_drop;

    // The checksum byte is the one on dados right now; drink and size are stored.
    assign frame_ok = (dados == (CABECALHO ^ bebida_reg ^ tamanho_reg))
                   && (bebida_reg < N_BEB_B)
                   && (tamanho_reg != 8'd0)
                   && (tamanho_reg <= 8'd3);

    assign fila_vazia = (count_reg == '0);
    assign fila_cheia = (count_reg == CHEIA_VAL);
    assign ocupacao   = count_reg;

    assign pedido_valido  = !fila_vazia;
    assign pedido_bebida  = fila_vazia ? 2'd0 : mem_reg[rd_ptr_reg][3:2];
    assign pedido_tamanho = fila_vazia ? 2'd0 : mem_reg[rd_ptr_reg][1:0];

    assign erro        = erro_reg;
    assign erro_codigo = erro_codigo_reg;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign pop       = pedido_valido && pedido_aceito;
    assign push_ok   = push_req_reg && (!fila_cheia || pop);
    assign push_drop = push_req_reg && fila_cheia && !pop;

    // Frame parser with inter-byte timeout; a byte on the timeout cycle wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_reg      <= ESPERA_CAB;
            timer_reg       <= '0;
            bebida_reg      <= 8'd0;
            tamanho_reg     <= 8'd0;
            push_req_reg    <= 1'b0;
            push_dado_reg   <= 4'd0;
            erro_reg        <= 1'b0;
            erro_codigo_reg <= 2'd0;
        end else begin
            erro_reg     <= 1'b0;
            push_req_reg <= 1'b0;
            if (push_drop) begin
                erro_reg        <= 1'b1;
                erro_codigo_reg <= COD_CHEIA;
            end
            if (pronto) begin
                timer_reg <= '0;
                case (estado_reg)
                    ESPERA_CAB: begin
                        if (dados == CABECALHO) estado_reg <= ESPERA_BEB;
                    end
                    ESPERA_BEB: begin
                        bebida_reg <= dados;
                        estado_reg <= ESPERA_TAM;
                    end
                    ESPERA_TAM: begin
                        tamanho_reg <= dados;
                        estado_reg  <= ESPERA_CHK;
                    end
                    ESPERA_CHK: begin
                        estado_reg <= ESPERA_CAB;
                        if (frame_ok) begin
                            push_req_reg  <= 1'b1;
                            push_dado_reg <= {bebida_reg[1:0], tamanho_reg[1:0]};
                        end else begin
                            erro_reg        <= 1'b1;
                            erro_codigo_reg <= COD_INVALIDO;
                        end
                    end
                    default: estado_reg <= ESPERA_CAB;
                endcase
            end else if (estado_reg != ESPERA_CAB) begin
                if (timer_reg == TIMER_ULTIMO) begin
                    estado_reg      <= ESPERA_CAB;
                    timer_reg       <= '0;
                    erro_reg        <= 1'b1;
                    erro_codigo_reg <= COD_TIMEOUT;
                end else begin
                    timer_reg <= timer_reg + 1'b1;
                end
            end
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Queue storage; contents are don't-care while empty, so no reset needed.
    always_ff @(posedge clock) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= push_dado_reg;
    end

endmodule
